// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: launches registered operands, waits a fixed
// settle time, captures the result and holds it under backpressure. Maintains an accumulator.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_use_acc,
    output logic [15:0] alu_input1,
    output logic [15:0] alu_input2,
    output logic [3:0]  alu_op_code,
    input  logic [31:0] alu_output1,
    input  logic [1:0]  alu_err_code,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic [31:0] acc,
    input  logic        acc_clr,
    output logic [7:0]  err_count,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

    state_e      r_state, w_state_d;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic [15:0] r_in1, r_in2;
    logic [3:0]  r_op;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_err;
    logic [31:0] r_acc;
    logic [7:0]  r_err_cnt;

    logic w_accept;
    logic w_capture;

    // r_run keeps cmd_ready low while reset is held and until the first edge after release.
    assign cmd_ready   = (r_state == StIdle) && r_run;
    assign rsp_valid   = (r_state == StResp);
    assign busy        = (r_state != StIdle);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_capture   = (r_state == StWait) && (r_cnt == 4'd0);

    assign alu_input1  = r_in1;
    assign alu_input2  = r_in2;
    assign alu_op_code = r_op;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign acc         = r_acc;
    assign err_count   = r_err_cnt;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StWait;
            StWait:  if (w_capture) w_state_d = StResp;
            StResp:  if (rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_in1 <= 16'd0;
            r_in2 <= 16'd0;
            r_op  <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CntLoad;
            r_op  <= cmd_op;
            r_in2 <= cmd_b;
            // Operand taken from the pre-clear accumulator even if acc_clr is also high.
            r_in1 <= cmd_use_acc ? r_acc[15:0] : cmd_a;
        end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 2'd0;
        end else if (w_capture) begin
            r_rsp_data <= alu_output1;
            r_rsp_err  <= alu_err_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= 32'd0;
            r_err_cnt <= 8'd0;
        end else begin
            if (acc_clr) begin
                r_acc <= 32'd0;
            end else if (w_capture && (alu_err_code == 2'd0)) begin
                r_acc <= alu_output1;
            end
            if (w_capture && (alu_err_code != 2'd0) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_op_sequencer;

    localparam int unsigned SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_use_acc;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [3:0]  alu_op_code;
    logic [31:0] alu_output1;
    logic [1:0]  alu_err_code;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [31:0] acc;
    logic        acc_clr;
    logic [7:0]  err_count;
    logic        busy;

    int          total;
    int          bad;
    logic [31:0] m_acc;
    logic [7:0]  m_err;
    logic [33:0] sb_q[$];

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_use_acc  (cmd_use_acc),
        .alu_input1   (alu_input1),
        .alu_input2   (alu_input2),
        .alu_op_code  (alu_op_code),
        .alu_output1  (alu_output1),
        .alu_err_code (alu_err_code),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .acc          (acc),
        .acc_clr      (acc_clr),
        .err_count    (err_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] d, output logic [1:0] e);
        d = 32'd0;
        e = 2'd0;
        case (op)
            4'd0: d = 32'(a) + 32'(b);
            4'd1: d = 32'(a) - 32'(b);
            4'd2: d = 32'(a) * 32'(b);
            4'd3: if (b == 16'd0) e = 2'b10; else d = 32'(a) / 32'(b);
            4'd4: if (b == 16'd0) e = 2'b10; else d = 32'(a) % 32'(b);
            default: e = 2'b01;
        endcase
    endtask

    always_comb begin
        alu_output1  = 32'd0;
        alu_err_code = 2'd0;
        alu_ref(alu_op_code, alu_input1, alu_input2, alu_output1, alu_err_code);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic ua, input int hold, input logic clr);
        int          n;
        logic [15:0] opa;
        logic [31:0] ed;
        logic [1:0]  ee;
        logic [33:0] e;
        logic [31:0] held;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        acc_clr     = clr;
        opa = ua ? m_acc[15:0] : a;
        alu_ref(op, opa, b, ed, ee);
        sb_q.push_back({ee, ed});
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_clr   = 1'b0;
        if (clr) m_acc = 32'd0;
        chk("launch_in1", 32'(alu_input1), 32'(opa));
        chk("launch_in2", 32'(alu_input2), 32'(b));
        chk("launch_op", 32'(alu_op_code), 32'(op));
        chk("acc_after_accept", acc, m_acc);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(SETTLE));
        held = rsp_data;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, held);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(e[33:32]));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (e[33:32] == 2'd0) m_acc = e[31:0];
        else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        chk("acc_after_rsp", acc, m_acc);
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        m_acc       = 32'd0;
        m_err       = 8'd0;
        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_a       = 16'd0;
        cmd_b       = 16'd0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;
        acc_clr     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc", acc, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in1", 32'(alu_input1), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Mul 11*15, then chained add through the accumulator.
        run_cmd(4'd2, 16'd11, 16'd15, 1'b0, 0, 1'b0);
        chk("mul_acc_165", acc, 32'd165);
        run_cmd(4'd0, 16'd999, 16'd5, 1'b1, 0, 1'b0);
        chk("chain_in1_165", 32'(alu_input1), 32'd165);
        chk("chain_acc_170", acc, 32'd170);

        // Divide by zero: error flag, accumulator kept.
        run_cmd(4'd3, 16'd11, 16'd0, 1'b0, 0, 1'b0);
        chk("div0_err", 32'(rsp_err), 32'd2);
        chk("div0_acc_kept", acc, 32'd170);
        chk("div0_errcnt", 32'(err_count), 32'd1);

        // Backpressure for 10 cycles on a subtract, then a mod accepted straight after.
        run_cmd(4'd1, 16'd11, 16'd15, 1'b0, 10, 1'b0);
        chk("sub_wrap", acc, 32'hFFFF_FFFC);
        run_cmd(4'd4, 16'd100, 16'd7, 1'b0, 0, 1'b0);
        chk("mod_acc", acc, 32'd2);

        // Standalone clear leaves err_count alone.
        acc_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_clr = 1'b0;
        m_acc = 32'd0;
        chk("clr_acc", acc, 32'd0);
        chk("clr_errcnt", 32'(err_count), 32'd1);

        // Clear coincident with a use_acc accept: operand is the pre-clear value.
        run_cmd(4'd2, 16'd300, 16'd3, 1'b0, 0, 1'b0);
        run_cmd(4'd0, 16'd0, 16'd1, 1'b1, 0, 1'b1);
        chk("clr_accept_acc", acc, 32'd901);

        // Reset in the middle of WAIT aborts the transaction.
        cmd_valid = 1'b1;
        cmd_op    = 4'd2;
        cmd_a     = 16'd7;
        cmd_b     = 16'd7;
        cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_acc", acc, 32'd0);
        chk("midrst_in1", 32'(alu_input1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 32'd0;
        m_err = 8'd0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_acc", acc, 32'd0);

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            run_cmd(4'd3, 16'd11, 16'd0, 1'b0, 0, 1'b0);
        end
        chk("errcnt_sat", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
